// File: rtl/mem_paged_nent.sv
// Paged block RAM with one append counter per page.
// The producer appends words without an address and the consumer reads by
// (page, index). Counts, fullness and sticky overflow are tracked per page.
module mem_paged_nent #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    NPAGES          = 8,
    parameter int    PAGE_DEPTH      = 64,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int   PW              = $clog2(NPAGES),
    localparam int   AW              = $clog2(PAGE_DEPTH),
    localparam int   NW              = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_page,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 clr_en,
    input  logic [PW-1:0]        clr_page,
    input  logic                 rd_en,
    input  logic [PW-1:0]        rd_page,
    input  logic [AW-1:0]        rd_index,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_inrange,
    input  logic [PW-1:0]        nent_page,
    output logic [NW-1:0]        nent,
    output logic [NPAGES-1:0]    full,
    output logic [NPAGES-1:0]    overflow
);

    localparam logic [NW-1:0] DEPTH_N = NW'(PAGE_DEPTH);

    (* ram_style = "block" *) logic [RAM_WIDTH-1:0] ram [NPAGES*PAGE_DEPTH];

    logic [NW-1:0]        count    [NPAGES];
    logic [NW-1:0]        count_nx [NPAGES];
    logic [NPAGES-1:0]    ovf_nx;
    logic                 wr_same_clr;
    logic                 wr_ok;
    logic [AW-1:0]        wr_idx;
    logic [RAM_WIDTH-1:0] ram_q;
    logic                 valid_s1;
    logic                 inrange_s1;

    // Decide whether this cycle's append lands in RAM and at which index;
    // a clear of the same page rewinds the append to index 0.
    always_comb begin
        wr_same_clr = clr_en && (clr_page == wr_page);
        wr_ok       = wr_en && (wr_same_clr || (count[wr_page] < DEPTH_N));
        wr_idx      = wr_same_clr ? '0 : count[wr_page][AW-1:0];
    end

    // Next count and overflow per page: clear applies first, then the append.
    always_comb begin
        ovf_nx = overflow;
        for (int p = 0; p < NPAGES; p++) begin
            count_nx[p] = count[p];
            if (clr_en && (clr_page == PW'(p))) begin
                count_nx[p] = '0;
                ovf_nx[p]   = 1'b0;
            end
            if (wr_en && (wr_page == PW'(p))) begin
                if (count_nx[p] < DEPTH_N) begin
                    count_nx[p] = count_nx[p] + 1'b1;
                end else begin
                    ovf_nx[p] = 1'b1;
                end
            end
        end
    end

    // Page counters and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPAGES; p++) begin
                count[p] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int p = 0; p < NPAGES; p++) begin
                count[p] <= count_nx[p];
            end
            overflow <= ovf_nx;
        end
    end

    // A page is full when its count has reached the page depth.
    always_comb begin
        full = '0;
        for (int p = 0; p < NPAGES; p++) begin
            full[p] = (count[p] == DEPTH_N);
        end
    end

    // Registered entry count of the queried page, showing pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nent <= '0;
        end else begin
            nent <= count[nent_page];
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[{wr_page, wr_idx}] <= wr_data;
        end
    end

    // First read stage: RAM output register plus valid and range tags.
    // Reading before the write lands gives read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q      <= '0;
            valid_s1   <= 1'b0;
            inrange_s1 <= 1'b0;
        end else begin
            valid_s1   <= rd_en;
            inrange_s1 <= rd_en && ({1'b0, rd_index} < count[rd_page]);
            if (rd_en) begin
                ram_q <= ram[{rd_page, rd_index}];
            end
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
            assign rd_data    = ram_q;
            assign rd_valid   = valid_s1;
            assign rd_inrange = inrange_s1;
        end else begin : g_high_performance
            // Second read stage: output register that only loads on valid data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data    <= '0;
                    rd_valid   <= 1'b0;
                    rd_inrange <= 1'b0;
                end else begin
                    rd_valid   <= valid_s1;
                    rd_inrange <= inrange_s1;
                    if (valid_s1) begin
                        rd_data <= ram_q;
                    end
                end
            end
        end
    endgenerate

endmodule
